// File: rtl/vga_scorebar_gen.sv
// rtl/vga_scorebar_gen.sv - score-bar pixel renderer with inc/dec/clr, level readback and paced drawing
// Streams one registered pixel per cycle, column-major, to grow, shrink or blank the bar.
module vga_scorebar_gen #(
  parameter int         COORD_W  = 9,
  parameter int         X0       = 10,
  parameter int         Y0       = 44,
  parameter int         SEG_W    = 10,
  parameter int         SEG_H    = 5,
  parameter int         MAX_SEGS = 29,
  parameter logic [5:0] FG       = 6'b001001,
  parameter logic [5:0] BG       = 6'b111111,
  parameter int         PACE     = 20000,
  localparam int        LW       = $clog2(MAX_SEGS + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  output logic               ready,
  output logic               done,
  output logic [LW-1:0]      level,
  output logic               full,
  output logic               empty,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [5:0]         colour,
  output logic               writeEn
);

  localparam int NCOLS_ALL = MAX_SEGS * SEG_W;
  localparam int COL_W     = (NCOLS_ALL > 1) ? $clog2(NCOLS_ALL) : 1;
  localparam int ROW_W     = (SEG_H > 1) ? $clog2(SEG_H) : 1;
  localparam int PACE_W    = (PACE > 1) ? $clog2(PACE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PACE, S_DONE} state_t;
  typedef enum logic [1:0] {OP_INC, OP_DEC, OP_CLR} op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [LW-1:0]        level_q, level_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [PACE_W-1:0]    pace_q, pace_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [5:0]           colour_q, colour_d;
  logic                 we_q, we_d;

  logic                 start;
  logic                 next_col;
  logic [COL_W-1:0]     col_last;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    level_d  = level_q;
    col_d    = col_q;
    row_d    = row_q;
    pace_d   = pace_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    start    = 1'b0;
    next_col = 1'b0;
    col_last = (op_q == OP_CLR) ? COL_W'(NCOLS_ALL - 1) : COL_W'(SEG_W - 1);

    case (state_q)
      S_IDLE: begin
        // Saturated inc/dec skip drawing and go straight to the done pulse.
        if (clr) begin
          start    = 1'b1;
          op_d     = OP_CLR;
          x_d      = COORD_W'(X0);
          colour_d = BG;
        end else if (dec) begin
          if (level_q == '0) begin
            state_d = S_DONE;
          end else begin
            start    = 1'b1;
            op_d     = OP_DEC;
            x_d      = COORD_W'(X0 + (int'(level_q) - 1) * SEG_W);
            colour_d = BG;
          end
        end else if (inc) begin
          if (level_q == LW'(MAX_SEGS)) begin
            state_d = S_DONE;
          end else begin
            start    = 1'b1;
            op_d     = OP_INC;
            x_d      = COORD_W'(X0 + int'(level_q) * SEG_W);
            colour_d = FG;
          end
        end
      end
      S_DRAW: begin
        if (row_q != ROW_W'(SEG_H - 1)) begin
          row_d = row_q + 1'b1;
          y_d   = y_q + 1'b1;
          we_d  = 1'b1;
        end else if (col_q == col_last) begin
          state_d = S_DONE;
          case (op_q)
            OP_INC:  level_d = level_q + 1'b1;
            OP_DEC:  level_d = level_q - 1'b1;
            default: level_d = '0;
          endcase
        end else if (PACE > 0 && op_q != OP_CLR) begin
          state_d = S_PACE;
          pace_d  = PACE_W'((PACE > 0) ? PACE - 1 : 0);
        end else begin
          next_col = 1'b1;
        end
      end
      S_PACE: begin
        if (pace_q == '0) next_col = 1'b1;
        else              pace_d   = pace_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_DRAW;
      y_d     = COORD_W'(Y0);
      col_d   = '0;
      row_d   = '0;
      we_d    = 1'b1;
    end
    if (next_col) begin
      state_d = S_DRAW;
      col_d   = col_q + 1'b1;
      row_d   = '0;
      x_d     = x_q + 1'b1;
      y_d     = COORD_W'(Y0);
      we_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= OP_INC;
      level_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      pace_q   <= '0;
      x_q      <= COORD_W'(X0);
      y_q      <= COORD_W'(Y0);
      colour_q <= BG;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      level_q  <= level_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pace_q   <= pace_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_DONE);
  assign level   = level_q;
  assign full    = (level_q == LW'(MAX_SEGS));
  assign empty   = (level_q == '0);
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;

endmodule

// File: tb/tb_vga_scorebar_gen.sv
// tb/tb_vga_scorebar_gen.sv - randomized self-checking bench for vga_scorebar_gen
// Two instances (unpaced and PACE=3) share stimulus; sel picks the one observed.
module tb_vga_scorebar_gen;

  localparam int COORD_W  = 9;
  localparam int X0       = 10;
  localparam int Y0       = 44;
  localparam int SEG_W    = 10;
  localparam int SEG_H    = 5;
  localparam int MAX_SEGS = 29;
  localparam int FG       = 9;
  localparam int BG       = 63;
  localparam int LW       = 5;
  localparam int OP_INC   = 0;
  localparam int OP_DEC   = 1;
  localparam int OP_CLR   = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic inc = 1'b0, dec = 1'b0, clr = 1'b0;
  logic sel = 1'b0;

  logic rdy0, done0, full0, empty0, we0;
  logic rdy3, done3, full3, empty3, we3;
  logic [LW-1:0] lvl0, lvl3;
  logic [COORD_W-1:0] x0o, y0o, x3o, y3o;
  logic [5:0] c0o, c3o;

  logic w_ready, w_done, w_full, w_empty, w_we;
  logic [LW-1:0] w_level;
  logic [COORD_W-1:0] w_x, w_y;
  logic [5:0] w_col;

  vga_scorebar_gen #(.PACE(0)) dut0 (
    .clk(clk), .resetn(resetn), .inc(inc), .dec(dec), .clr(clr),
    .ready(rdy0), .done(done0), .level(lvl0), .full(full0), .empty(empty0),
    .x(x0o), .y(y0o), .colour(c0o), .writeEn(we0)
  );

  vga_scorebar_gen #(.PACE(3)) dut3 (
    .clk(clk), .resetn(resetn), .inc(inc), .dec(dec), .clr(clr),
    .ready(rdy3), .done(done3), .level(lvl3), .full(full3), .empty(empty3),
    .x(x3o), .y(y3o), .colour(c3o), .writeEn(we3)
  );

  assign w_ready = sel ? rdy3   : rdy0;
  assign w_done  = sel ? done3  : done0;
  assign w_full  = sel ? full3  : full0;
  assign w_empty = sel ? empty3 : empty0;
  assign w_we    = sel ? we3    : we0;
  assign w_level = sel ? lvl3   : lvl0;
  assign w_x     = sel ? x3o    : x0o;
  assign w_y     = sel ? y3o    : y0o;
  assign w_col   = sel ? c3o    : c0o;

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   g_done_at;
  int   g_level_at_done;
  bit   g_ready_cmd, g_ready_done, g_full_done, g_empty_done;

  // Reference: pixel list of one command, time offset relative to the accept cycle.
  task automatic model_cmd(input int op, input int lvl, input int pace,
                           output int done_at, output int nlvl);
    int base, ncols, p, colr, t;
    pix_t px;
    exp_q.delete();
    nlvl    = lvl;
    done_at = 1;
    if ((op == OP_INC && lvl == MAX_SEGS) || (op == OP_DEC && lvl == 0)) return;
    if (op == OP_CLR) begin
      base = X0; ncols = MAX_SEGS * SEG_W; p = 0; colr = BG; nlvl = 0;
    end else if (op == OP_INC) begin
      base = X0 + lvl * SEG_W; ncols = SEG_W; p = pace; colr = FG; nlvl = lvl + 1;
    end else begin
      base = X0 + (lvl - 1) * SEG_W; ncols = SEG_W; p = pace; colr = BG; nlvl = lvl - 1;
    end
    t = 0;
    for (int c = 0; c < ncols; c++) begin
      for (int r = 0; r < SEG_H; r++) begin
        t = 1 + c * (SEG_H + p) + r;
        px.x = base + c; px.y = Y0 + r; px.c = colr; px.t = t;
        exp_q.push_back(px);
      end
    end
    done_at = t + 1;
  endtask

  function automatic int pixel_diffs();
    int n;
    int ne = exp_q.size();
    int ng = got_q.size();
    n = (ne > ng) ? ne - ng : ng - ne;
    for (int i = 0; i < ne && i < ng; i++) begin
      if (exp_q[i].x != got_q[i].x || exp_q[i].y != got_q[i].y ||
          exp_q[i].c != got_q[i].c || exp_q[i].t != got_q[i].t) n++;
    end
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_cmd(input bit i, input bit d, input bit c, input int mid_inc);
    pix_t px;
    got_q.delete();
    g_done_at = -1;
    @(negedge clk);
    g_ready_cmd = w_ready;
    inc = i; dec = d; clr = c;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (w_we) begin
        px.x = int'(w_x); px.y = int'(w_y); px.c = int'(w_col); px.t = k;
        got_q.push_back(px);
      end
      if (w_done) begin
        g_done_at       = k;
        g_level_at_done = int'(w_level);
        g_ready_done    = w_ready;
        g_full_done     = w_full;
        g_empty_done    = w_empty;
        break;
      end
      inc = (k == mid_inc);
      @(negedge clk);
    end
    inc = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", w_ready); end
    checks++; if (w_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", w_done); end
    checks++; if (w_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", w_we); end
    checks++; if (w_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", w_level); end
    checks++; if (w_empty !== 1'b1 || w_full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1 0", w_empty, w_full); end
    checks++; if (int'(w_x) != X0 || int'(w_y) != Y0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected %0d,%0d", w_x, w_y, X0, Y0); end
    checks++; if (int'(w_col) != BG) begin errors++; $display("FAIL reset_colour: got %0d expected %0d", w_col, BG); end
  endtask

  task automatic test_inc_unpaced();
    int ed, el, nd;
    sel = 1'b0;
    do_reset();
    model_cmd(OP_INC, 0, 0, ed, el);
    do_cmd(1'b1, 1'b0, 1'b0, -1);
    nd = pixel_diffs();
    checks++; if (g_ready_cmd !== 1'b1) begin errors++; $display("FAIL inc_ready: got %0b expected 1", g_ready_cmd); end
    checks++; if (nd != 0) begin errors++; $display("FAIL inc_pixels: got %0d bad of %0d expected 0 bad", nd, got_q.size()); end
    checks++; if (g_done_at != ed) begin errors++; $display("FAIL inc_done_at: got %0d expected %0d", g_done_at, ed); end
    checks++; if (g_level_at_done != el || g_empty_done !== 1'b0) begin errors++; $display("FAIL inc_level: got %0d empty=%0b expected %0d empty=0", g_level_at_done, g_empty_done, el); end
    checks++; if (g_ready_done !== 1'b0) begin errors++; $display("FAIL inc_ready_in_done: got %0b expected 0", g_ready_done); end
  endtask

  task automatic test_pacing();
    int ed, el, nd, lv;
    sel = 1'b1;
    do_reset();
    lv = 0;
    for (int n = 0; n < 2; n++) begin
      model_cmd((n == 0) ? OP_INC : OP_DEC, lv, 3, ed, el);
      do_cmd(n == 0, n == 1, 1'b0, -1);
      nd = pixel_diffs();
      checks++; if (nd != 0) begin errors++; $display("FAIL pace_pixels%0d: got %0d bad of %0d expected 0 bad", n, nd, got_q.size()); end
      checks++; if (g_done_at != ed) begin errors++; $display("FAIL pace_done_at%0d: got %0d expected %0d", n, g_done_at, ed); end
      checks++; if (g_level_at_done != el) begin errors++; $display("FAIL pace_level%0d: got %0d expected %0d", n, g_level_at_done, el); end
      lv = el;
    end
  endtask

  task automatic test_dec_clr();
    int ed, el, nd;
    sel = 1'b0;
    do_reset();
    do_cmd(1'b1, 1'b0, 1'b0, -1);
    do_cmd(1'b1, 1'b0, 1'b0, -1);
    model_cmd(OP_DEC, 2, 0, ed, el);
    do_cmd(1'b0, 1'b1, 1'b0, -1);
    nd = pixel_diffs();
    checks++; if (nd != 0) begin errors++; $display("FAIL dec_pixels: got %0d bad of %0d expected 0 bad", nd, got_q.size()); end
    checks++; if (g_done_at != ed || g_level_at_done != el) begin errors++; $display("FAIL dec_done: got at=%0d level=%0d expected at=%0d level=%0d", g_done_at, g_level_at_done, ed, el); end
    model_cmd(OP_CLR, 1, 0, ed, el);
    do_cmd(1'b0, 1'b0, 1'b1, -1);
    nd = pixel_diffs();
    checks++; if (nd != 0 || got_q.size() != 1450) begin errors++; $display("FAIL clr_pixels: got %0d bad, %0d writes expected 0 bad, 1450 writes", nd, got_q.size()); end
    checks++; if (g_done_at != ed || g_level_at_done != 0 || g_empty_done !== 1'b1) begin errors++; $display("FAIL clr_done: got at=%0d level=%0d empty=%0b expected at=%0d level=0 empty=1", g_done_at, g_level_at_done, g_empty_done, ed); end
  endtask

  task automatic test_saturation();
    int miss;
    sel = 1'b0;
    do_reset();
    miss = 0;
    for (int n = 0; n < MAX_SEGS; n++) begin
      do_cmd(1'b1, 1'b0, 1'b0, -1);
      if (g_done_at < 0) miss++;
    end
    checks++; if (miss != 0 || w_level !== 5'd29 || w_full !== 1'b1) begin errors++; $display("FAIL fill_to_max: got level=%0d full=%0b timeouts=%0d expected 29 1 0", w_level, w_full, miss); end
    do_cmd(1'b1, 1'b0, 1'b0, -1);
    checks++; if (got_q.size() != 0 || g_done_at != 1) begin errors++; $display("FAIL inc_full: got writes=%0d done_at=%0d expected 0 1", got_q.size(), g_done_at); end
    checks++; if (g_level_at_done != 29 || g_full_done !== 1'b1) begin errors++; $display("FAIL inc_full_level: got %0d full=%0b expected 29 1", g_level_at_done, g_full_done); end
    do_cmd(1'b0, 1'b0, 1'b1, -1);
    do_cmd(1'b0, 1'b1, 1'b0, -1);
    checks++; if (got_q.size() != 0 || g_done_at != 1) begin errors++; $display("FAIL dec_empty: got writes=%0d done_at=%0d expected 0 1", got_q.size(), g_done_at); end
    checks++; if (g_level_at_done != 0 || g_empty_done !== 1'b1) begin errors++; $display("FAIL dec_empty_level: got %0d empty=%0b expected 0 1", g_level_at_done, g_empty_done); end
  endtask

  task automatic test_priority();
    int ed, el, nd;
    sel = 1'b0;
    do_reset();
    repeat (3) do_cmd(1'b1, 1'b0, 1'b0, -1);
    model_cmd(OP_CLR, 3, 0, ed, el);
    do_cmd(1'b1, 1'b1, 1'b1, 100);
    nd = pixel_diffs();
    checks++; if (nd != 0) begin errors++; $display("FAIL prio_pixels: got %0d bad of %0d expected 0 bad", nd, got_q.size()); end
    checks++; if (g_done_at != ed || g_level_at_done != el) begin errors++; $display("FAIL prio_done: got at=%0d level=%0d expected at=%0d level=%0d", g_done_at, g_level_at_done, ed, el); end
    repeat (3) @(negedge clk);
    checks++; if (w_level !== 5'd0 || w_ready !== 1'b1 || w_we !== 1'b0) begin errors++; $display("FAIL prio_after: got level=%0d ready=%0b we=%0b expected 0 1 0", w_level, w_ready, w_we); end
  endtask

  task automatic test_reset_mid_draw();
    int n, ed, el, nd;
    bit seen_done;
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (w_we) n++;
      if (n >= 20) break;
      @(negedge clk);
    end
    checks++; if (n != 20) begin errors++; $display("FAIL mid_writes: got %0d expected 20", n); end
    resetn = 1'b0;
    #1;
    checks++; if (w_we !== 1'b0 || w_level !== 5'd0 || w_ready !== 1'b1 || w_done !== 1'b0) begin errors++; $display("FAIL mid_reset: got we=%0b level=%0d ready=%0b done=%0b expected 0 0 1 0", w_we, w_level, w_ready, w_done); end
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (w_done) seen_done = 1'b1;
    end
    checks++; if (seen_done) begin errors++; $display("FAIL mid_no_done: got done pulse expected none"); end
    model_cmd(OP_INC, 0, 0, ed, el);
    do_cmd(1'b1, 1'b0, 1'b0, -1);
    nd = pixel_diffs();
    checks++; if (nd != 0 || g_done_at != ed || g_level_at_done != el) begin errors++; $display("FAIL mid_redraw: got bad=%0d at=%0d level=%0d expected 0 %0d %0d", nd, g_done_at, g_level_at_done, ed, el); end
  endtask

  task automatic test_random();
    int ed, el, nd, lv, op, r;
    sel = 1'b1;
    do_reset();
    lv = 0;
    for (int n = 0; n < 25; n++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? OP_INC : (r < 9) ? OP_DEC : OP_CLR;
      model_cmd(op, lv, 3, ed, el);
      do_cmd(op == OP_INC, op == OP_DEC, op == OP_CLR, -1);
      nd = pixel_diffs();
      checks++; if (nd != 0 || g_done_at != ed) begin errors++; $display("FAIL rand%0d_op%0d: got bad=%0d at=%0d expected 0 %0d", n, op, nd, g_done_at, ed); end
      checks++; if (g_level_at_done != el) begin errors++; $display("FAIL rand%0d_level: got %0d expected %0d", n, g_level_at_done, el); end
      lv = el;
    end
  endtask

  initial begin
    test_reset();
    test_inc_unpaced();
    test_pacing();
    test_dec_clr();
    test_saturation();
    test_priority();
    test_reset_mid_draw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
